// File: rtl/uart_cmd_pkg.sv
// Shared types and sizes for the UART command responder.
package uart_cmd_pkg;

   localparam int BYTE_W    = 8;
   localparam int CMD_BYTES = 3;
   localparam int CMD_W     = 24;

   typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} asm_state_t;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start detect, mid-bit sampling,
// stop-bit framing check. rx_vld / rx_ferr / rx_start are 1-cycle pulses.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_vld,
   output logic       rx_ferr,
   output logic       rx_start
);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);

   logic             rx_s1, rx_s2, rx_prev;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       sh;

   // The shift register is complete and stable when rx_vld pulses.
   assign rx_byte = sh;

   // Synchronize RX; preset high so reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Frame receiver: start qualify at half bit, data/stop at bit centres.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= R_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         sh       <= '0;
         rx_vld   <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_start <= 1'b0;
      end else begin
         rx_vld   <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_start <= 1'b0;
         case (state)
            R_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  state    <= R_START;
                  cnt      <= '0;
                  rx_start <= 1'b1;
               end
            end
            R_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // A line back high at mid-start was a glitch, not a frame.
                  if (rx_s2) begin
                     state <= R_IDLE;
                  end else begin
                     state   <= R_DATA;
                     bit_cnt <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  sh  <= {rx_s2, sh[7:1]};
                  if (bit_cnt == 3'd7) state <= R_STOP;
                  else                 bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (cnt == CNT_LAST) begin
                  state <= R_IDLE;
                  cnt   <= '0;
                  if (rx_s2) rx_vld  <= 1'b1;
                  else       rx_ferr <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_slv.sv
// UART command responder: assembles three RX bytes into a 24-bit command
// and serializes a one-byte response on TX. RX and TX are independent.
// Optional macro CMD_TIMEOUT_EN: abort a partial command after an
// inter-byte gap of TIMEOUT_BITS bit times.
module uart_cmd_slv
   import uart_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RX,
   output logic              TX,
   output logic [CMD_W-1:0]  cmd,
   output logic              cmd_rdy,
   input  logic              clr_cmd_rdy,
   input  logic [BYTE_W-1:0] resp,
   input  logic              send_resp,
   output logic              resp_sent,
   output logic              frm_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   // Elaboration-time guard against unusable configurations.
   if (CLKS_PER_BIT < 8 || (CLKS_PER_BIT % 2) != 0 || TIMEOUT_BITS < 1 ||
       CMD_W != CMD_BYTES * BYTE_W) begin : g_cfg_err
      $error("uart_cmd_slv: invalid parameter set");
   end

   logic [BYTE_W-1:0] rx_byte;
   logic              rx_vld, rx_ferr, rx_start;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (RX),
      .rx_byte  (rx_byte),
      .rx_vld   (rx_vld),
      .rx_ferr  (rx_ferr),
      .rx_start (rx_start)
   );

   asm_state_t               asm_state;
   logic [CMD_W-1:BYTE_W]    shadow;
   logic                     tmo_hit;

`ifdef CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_BITS * CLKS_PER_BIT);
   logic [TMO_W-1:0] tmo_cnt;

   // Inter-byte gap counter; only runs mid-command and restarts on every start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               tmo_cnt <= '0;
      else if (asm_state == BYTE0 || rx_start)  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)              tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (tmo_cnt == TMO_MAX) && (asm_state != BYTE0);
`else
   assign tmo_hit = 1'b0;
`endif

   // Command assembler; cmd only moves when a full triple has arrived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_state <= BYTE0;
         shadow    <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         frm_err <= 1'b0;
         // Clear first so a same-cycle set below takes priority.
         if (clr_cmd_rdy || (rx_start && asm_state == BYTE0)) cmd_rdy <= 1'b0;
         if (rx_ferr) begin
            asm_state <= BYTE0;
            frm_err   <= 1'b1;
         end else if (rx_vld) begin
            case (asm_state)
               BYTE0: begin
                  shadow[23:16] <= rx_byte;
                  asm_state     <= BYTE1;
               end
               BYTE1: begin
                  shadow[15:8] <= rx_byte;
                  asm_state    <= BYTE2;
               end
               BYTE2: begin
                  cmd       <= {shadow[23:8], rx_byte};
                  cmd_rdy   <= 1'b1;
                  asm_state <= BYTE0;
               end
               default: asm_state <= BYTE0;
            endcase
         end else if (tmo_hit) begin
            asm_state <= BYTE0;
            frm_err   <= 1'b1;
         end
      end
   end

   tx_state_t         tx_state;
   logic [CNT_W-1:0]  tx_cnt;
   logic [2:0]        tx_bit;
   logic [BYTE_W-1:0] tx_sh;

   // Response serializer: start, 8 data LSB first, stop; TX is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state  <= IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_sh     <= '0;
         TX        <= 1'b1;
         resp_sent <= 1'b0;
      end else begin
         case (tx_state)
            IDLE: begin
               TX <= 1'b1;
               if (send_resp) begin
                  tx_sh     <= resp;
                  resp_sent <= 1'b0;
                  TX        <= 1'b0;
                  tx_cnt    <= '0;
                  tx_state  <= START;
               end
            end
            START: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  TX       <= tx_sh[0];
                  tx_sh    <= {1'b0, tx_sh[7:1]};
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     TX       <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     TX     <= tx_sh[0];
                     tx_sh  <= {1'b0, tx_sh[7:1]};
                     tx_bit <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt    <= '0;
                  resp_sent <= 1'b1;
                  tx_state  <= IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_slv.sv
// Directed bench for uart_cmd_slv at 16 clk/bit; RX driven on falling edges.
module tb_uart_cmd_slv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        RX = 1'b1;
   logic        TX;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic        frm_err;

   int errors = 0;
   int checks = 0;
   int ferr_cnt = 0;
   int ferr_base;
   logic [9:0] exp_frame;

   uart_cmd_slv #(.CLKS_PER_BIT(16), .TIMEOUT_BITS(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RX          (RX),
      .TX          (TX),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .frm_err     (frm_err)
   );

   always #5 clk = ~clk;

   // frm_err pulses are one cycle wide, so each is seen at exactly one falling edge.
   always @(negedge clk) if (frm_err === 1'b1) ferr_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Serialize one byte, called on a falling edge. With do_chk, cmd_rdy must
   // still be low 11 clk into the stop bit and high (with exp_cmd) 12 clk in.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                            input logic do_chk, input logic [23:0] exp_cmd);
      RX = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (16) @(negedge clk);
      end
      RX = stop_bit;
      if (do_chk) begin
         repeat (11) @(negedge clk);
         chk("rdy_before", {31'd0, cmd_rdy}, 32'd0);
         @(negedge clk);
         chk("rdy_after", {31'd0, cmd_rdy}, 32'd1);
         chk("cmd_value", {8'd0, cmd}, {8'd0, exp_cmd});
         repeat (4) @(negedge clk);
      end else begin
         repeat (16) @(negedge clk);
      end
      RX = 1'b1;
   endtask

   initial begin
      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tx", {31'd0, TX}, 32'd1);
      chk("rst_cmd", {8'd0, cmd}, 32'd0);
      chk("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("rst_sent", {31'd0, resp_sent}, 32'd0);
      chk("rst_ferr", {31'd0, frm_err}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Basic command and consumer clear
      send_byte(8'h55, 1'b1, 1'b0, 24'h0);
      send_byte(8'hAA, 1'b1, 1'b0, 24'h0);
      send_byte(8'h34, 1'b1, 1'b1, 24'h55AA34);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("clr_cmd_hold", {8'd0, cmd}, 32'h0055AA34);

      // Response 0xA5 with an ignored second strobe mid-frame
      exp_frame = {1'b1, 8'hA5, 1'b0};
      resp = 8'hA5;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      chk("tx_start_now", {31'd0, TX}, 32'd0);
      chk("tx_sent_clr", {31'd0, resp_sent}, 32'd0);
      repeat (8) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("tx_bit%0d", k), {31'd0, TX}, {31'd0, exp_frame[k]});
         if (k == 3) begin
            resp = 8'hFF;
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
            repeat (15) @(negedge clk);
         end else if (k < 9) begin
            repeat (16) @(negedge clk);
         end
      end
      repeat (7) @(negedge clk);
      chk("tx_sent_early", {31'd0, resp_sent}, 32'd0);
      @(negedge clk);
      chk("tx_sent_done", {31'd0, resp_sent}, 32'd1);
      repeat (10) @(negedge clk);
      chk("tx_no_refire", {31'd0, TX}, 32'd1);
      chk("tx_sent_hold", {31'd0, resp_sent}, 32'd1);

      // Framing error on the second byte; the bad triple is abandoned
      ferr_base = ferr_cnt;
      send_byte(8'h12, 1'b1, 1'b0, 24'h0);
      send_byte(8'h34, 1'b0, 1'b0, 24'h0);
      repeat (32) @(negedge clk);
      chk("ferr_pulse", ferr_cnt - ferr_base, 32'd1);
      chk("ferr_no_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("ferr_cmd_hold", {8'd0, cmd}, 32'h0055AA34);
      send_byte(8'h12, 1'b1, 1'b0, 24'h0);
      send_byte(8'h34, 1'b1, 1'b0, 24'h0);
      send_byte(8'h56, 1'b1, 1'b1, 24'h123456);
      chk("ferr_single", ferr_cnt - ferr_base, 32'd1);

      // 5-clk glitch: false start, nothing accepted, assembler still at BYTE0
      ferr_base = ferr_cnt;
      RX = 1'b0;
      repeat (5) @(negedge clk);
      RX = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_ferr", ferr_cnt - ferr_base, 32'd0);
      chk("glitch_cmd", {8'd0, cmd}, 32'h00123456);
      send_byte(8'hC3, 1'b1, 1'b0, 24'h0);
      send_byte(8'h3C, 1'b1, 1'b0, 24'h0);
      send_byte(8'h99, 1'b1, 1'b1, 24'hC33C99);

      // Reset in the middle of an RX frame and a TX frame
      RX = 1'b0;
      repeat (20) @(negedge clk);
      resp = 8'h00;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_tx_busy", {31'd0, TX}, 32'd0);
      rst_n = 1'b0;
      RX = 1'b1;
      #1;
      chk("mid_rst_tx", {31'd0, TX}, 32'd1);
      chk("mid_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("mid_rst_cmd", {8'd0, cmd}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_tx", {31'd0, TX}, 32'd1);
      send_byte(8'hDE, 1'b1, 1'b0, 24'h0);
      send_byte(8'hAD, 1'b1, 1'b0, 24'h0);
      send_byte(8'h01, 1'b1, 1'b1, 24'hDEAD01);

      // Inter-byte gap of 400 clk after the first byte
      ferr_base = ferr_cnt;
      send_byte(8'h11, 1'b1, 1'b0, 24'h0);
      repeat (300) @(negedge clk);
      chk("gap_ferr_300", ferr_cnt - ferr_base, 32'd0);
      repeat (100) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
      chk("gap_ferr_400", ferr_cnt - ferr_base, 32'd1);
      chk("gap_cmd_hold", {8'd0, cmd}, 32'h00DEAD01);
      send_byte(8'h22, 1'b1, 1'b0, 24'h0);
      send_byte(8'h33, 1'b1, 1'b0, 24'h0);
      send_byte(8'h44, 1'b1, 1'b1, 24'h223344);
`else
      chk("gap_ferr_400", ferr_cnt - ferr_base, 32'd0);
      send_byte(8'h22, 1'b1, 1'b0, 24'h0);
      send_byte(8'h33, 1'b1, 1'b1, 24'h112233);
      send_byte(8'h44, 1'b1, 1'b0, 24'h0);
      chk("gap_cmd_stable", {8'd0, cmd}, 32'h00112233);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
